// File: rtl/accumulator_pkg.sv
// Shared constants and types for the accumulator block.
// Defaults here set the parameter values used by accumulator and accumulator_adder.
package accumulator_pkg;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_CNT_WIDTH = 16;

  // Default-width sum with the carry-out in the top bit: {carry, sum}.
  typedef logic [DEFAULT_WIDTH:0] sum_carry_t;

endpackage : accumulator_pkg

// File: rtl/accumulator_adder.sv
// Combinational WIDTH-bit unsigned adder returning {carry, sum}.
module accumulator_adder
  import accumulator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic [WIDTH:0]   o_SUM
);

  // Zero-extend both operands so the carry lands in bit WIDTH.
  assign o_SUM = {1'b0, i_A} + {1'b0, i_B};

endmodule : accumulator_adder

// File: rtl/accumulator.sv
// Running-sum accumulator with saturating sample count and sticky overflow.
// Optional build macro: ACCUMULATOR_FORMAL_EN compiles in the formal property block;
// without it the module carries no formal logic and behaves identically.
module accumulator
  import accumulator_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 i_CLK,
  input  logic                 i_RESET,
  input  logic                 i_ENABLE,
  input  logic                 i_CLEAR,
  input  logic [WIDTH-1:0]     i_DATA_IN,
  output logic [WIDTH-1:0]     o_TOTAL,
  output logic [CNT_WIDTH-1:0] o_COUNT,
  output logic                 o_OVERFLOW
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]     r_total;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_overflow;
  logic [WIDTH:0]       w_sum;

  accumulator_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_A   (r_total),
    .i_B   (i_DATA_IN),
    .o_SUM (w_sum)
  );

  // State update with priority reset > clear > enable > hold.
  always_ff @(posedge i_CLK) begin
    if (i_RESET || i_CLEAR) begin
      r_total    <= {WIDTH{1'b0}};
      r_count    <= {CNT_WIDTH{1'b0}};
      r_overflow <= 1'b0;
    end else if (i_ENABLE) begin
      r_total    <= w_sum[WIDTH-1:0];
      r_overflow <= r_overflow | w_sum[WIDTH];
      if (r_count != CNT_MAX) begin
        r_count <= r_count + CNT_ONE;
      end else begin
        r_count <= r_count;
      end
    end else begin
      r_total    <= r_total;
      r_count    <= r_count;
      r_overflow <= r_overflow;
    end
  end

  assign o_TOTAL    = r_total;
  assign o_COUNT    = r_count;
  assign o_OVERFLOW = r_overflow;

`ifdef ACCUMULATOR_FORMAL_EN
  // Set once a reset edge has been seen; before that the state is undefined.
  logic f_past_valid;

  // Track whether history since the first reset is available.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      f_past_valid <= 1'b1;
    end else begin
      f_past_valid <= f_past_valid;
    end
  end

  // Properties relating each edge's outcome to the previous cycle's inputs and state.
  always @(posedge i_CLK) begin
    if (f_past_valid) begin
      if ($past(i_RESET) || $past(i_CLEAR)) begin
        assert (r_total == {WIDTH{1'b0}} && r_count == {CNT_WIDTH{1'b0}} && !r_overflow);
      end else if ($past(i_ENABLE)) begin
        assert (r_total == WIDTH'($past(r_total) + $past(i_DATA_IN)));
      end else begin
        assert (r_total == $past(r_total) && r_count == $past(r_count)
                && r_overflow == $past(r_overflow));
      end
      if (!$past(i_RESET) && !$past(i_CLEAR) && $past(r_overflow)) begin
        assert (r_overflow);
      end
      cover (r_overflow);
    end
    cover (i_RESET);
  end
`endif

endmodule : accumulator

// File: tb/tb_accumulator.sv
// Directed self-checking bench for accumulator. Two instances share stimulus:
// the default build and one with CNT_WIDTH=4 to exercise count saturation.
module tb_accumulator;

  logic        clk;
  logic        i_reset;
  logic        i_enable;
  logic        i_clear;
  logic [31:0] i_data;

  logic [31:0] o_total_a;
  logic [15:0] o_count_a;
  logic        o_ovf_a;
  logic [31:0] o_total_b;
  logic [3:0]  o_count_b;
  logic        o_ovf_b;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: plain arithmetic on the specification's rules.
  bit              model_valid = 1'b0;
  longint unsigned m_total     = 0;
  int              m_samples   = 0;
  bit              m_ovf       = 1'b0;

  accumulator dut_a (
    .i_CLK      (clk),
    .i_RESET    (i_reset),
    .i_ENABLE   (i_enable),
    .i_CLEAR    (i_clear),
    .i_DATA_IN  (i_data),
    .o_TOTAL    (o_total_a),
    .o_COUNT    (o_count_a),
    .o_OVERFLOW (o_ovf_a)
  );

  accumulator #(.WIDTH(32), .CNT_WIDTH(4)) dut_b (
    .i_CLK      (clk),
    .i_RESET    (i_reset),
    .i_ENABLE   (i_enable),
    .i_CLEAR    (i_clear),
    .i_DATA_IN  (i_data),
    .o_TOTAL    (o_total_b),
    .o_COUNT    (o_count_b),
    .o_OVERFLOW (o_ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, let the edge happen, then advance the model.
  task automatic step(input bit r, input bit c, input bit e, input logic [31:0] d);
    longint unsigned s;
    i_reset  = r;
    i_clear  = c;
    i_enable = e;
    i_data   = d;
    @(posedge clk);
    if (r || c) begin
      m_total   = 0;
      m_samples = 0;
      m_ovf     = 1'b0;
      if (r) model_valid = 1'b1;
    end else if (e) begin
      s = m_total + longint'(d);
      if (s > 64'h0000_0000_FFFF_FFFF) m_ovf = 1'b1;
      m_total   = s & 64'h0000_0000_FFFF_FFFF;
      m_samples = m_samples + 1;
    end
    #1;
  endtask

  // Compare both instances against the model on every falling edge after reset.
  always @(negedge clk) begin
    if (model_valid) begin
      check("cyc_total_a", o_total_a, m_total);
      check("cyc_count_a", o_count_a, (m_samples > 65535) ? 65535 : m_samples);
      check("cyc_ovf_a",   o_ovf_a,   m_ovf);
      check("cyc_total_b", o_total_b, m_total);
      check("cyc_count_b", o_count_b, (m_samples > 15) ? 15 : m_samples);
      check("cyc_ovf_b",   o_ovf_b,   m_ovf);
    end
  end

  initial begin
    i_reset = 1'b0; i_clear = 1'b0; i_enable = 1'b0; i_data = 32'h0;

    // 1. Reset with data present but enable low.
    step(1'b1, 1'b0, 1'b0, 32'h4000_0000);
    check("rst_total", o_total_a, 64'h0);
    check("rst_count", o_count_a, 64'h0);
    check("rst_ovf",   o_ovf_a,   64'h0);

    // 2. Accumulate 5, 7, 0x10.
    step(1'b0, 1'b0, 1'b1, 32'd5);
    check("acc_total_1", o_total_a, 64'd5);
    step(1'b0, 1'b0, 1'b1, 32'd7);
    check("acc_total_2", o_total_a, 64'd12);
    step(1'b0, 1'b0, 1'b1, 32'h10);
    check("acc_total_3", o_total_a, 64'd28);
    check("acc_count",   o_count_a, 64'd3);

    // 3. Hold with all-ones data and enable low.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    check("hold_total", o_total_a, 64'd28);
    check("hold_count", o_count_a, 64'd3);

    // 4. Bring total to 0xFFFFFFF0, then wrap with 0x20.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFD4);
    check("pre_wrap_total", o_total_a, 64'hFFFF_FFF0);
    check("pre_wrap_ovf",   o_ovf_a,   64'h0);
    step(1'b0, 1'b0, 1'b1, 32'h20);
    check("wrap_total", o_total_a, 64'h10);
    check("wrap_ovf",   o_ovf_a,   64'h1);
    step(1'b0, 1'b0, 1'b1, 32'h1);
    check("sticky_total", o_total_a, 64'h11);
    check("sticky_ovf",   o_ovf_a,   64'h1);

    // 5. Clear beats enable; reset+clear together; reset beats enable.
    step(1'b0, 1'b1, 1'b1, 32'd9);
    check("clr_total", o_total_a, 64'h0);
    check("clr_count", o_count_a, 64'h0);
    check("clr_ovf",   o_ovf_a,   64'h0);
    step(1'b0, 1'b0, 1'b1, 32'd3);
    check("post_clr_total", o_total_a, 64'd3);
    step(1'b1, 1'b1, 1'b1, 32'd9);
    check("rstclr_total", o_total_a, 64'h0);
    check("rstclr_count", o_count_a, 64'h0);
    step(1'b0, 1'b0, 1'b1, 32'd4);
    step(1'b1, 1'b0, 1'b1, 32'd6);
    check("rst_mid_total", o_total_a, 64'h0);

    // 6. Twenty enabled cycles of 1..20: sum 210, narrow count saturates.
    step(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 1; i <= 20; i++) step(1'b0, 1'b0, 1'b1, 32'(i));
    check("sat_total",   o_total_b, 64'd210);
    check("sat_count_b", o_count_b, 64'd15);
    check("sat_count_a", o_count_a, 64'd20);
    check("sat_ovf",     o_ovf_b,   64'h0);

    step(1'b0, 1'b0, 1'b0, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_accumulator
